ddram_byte_writer: RTL and testbench

//  Write side of the DDRAM byte port: packs byte-wide ioctl download writes

---
 rtl/ddram_byte_writer.sv | 168 ++++++++++++++++
 tb/tb_ddram_byte_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_byte_writer.sv
// Packs byte-wide ioctl download writes into 64-bit DDRAM single-beat writes with byte enables.
// Optional running byte checksum when DDRAM_BYTE_WRITER_CKSUM_EN is defined; O_CKSUM is 0 otherwise.
module ddram_byte_writer #(
  parameter logic [28:0] BASE_WADDR = 29'h0600_0000,
  parameter int          ADDR_W     = 25
) (
  input  logic              I_CLK,
  input  logic              I_RSTn,
  input  logic              I_DL,
  input  logic              I_WR,
  input  logic [ADDR_W-1:0] I_ADDR,
  input  logic [7:0]        I_DATA,
  output logic              O_WAIT,
  input  logic              DDRAM_BUSY,
  output logic              DDRAM_WE,
  output logic [28:0]       DDRAM_ADDR,
  output logic [63:0]       DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [15:0]       O_CKSUM
);

  localparam int WA_W = ADDR_W - 3;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FLUSH} state_t;

  state_t            state_q, state_d;
  logic              dl_q;
  logic              dl_rise;

  logic              buf_vld;
  logic [WA_W-1:0]   buf_waddr;
  logic [63:0]       buf_dat;
  logic [7:0]        buf_be;
  logic              out_vld;

  logic [2:0]        in_lane;
  logic [WA_W-1:0]   in_waddr;
  logic              accept;
  logic              same_word;
  logic [63:0]       merged_dat;
  logic [7:0]        merged_be;

  logic              ho_vld;
  logic [WA_W-1:0]   ho_waddr;
  logic [63:0]       ho_dat;
  logic [7:0]        ho_be;
  logic              buf_load;
  logic              buf_vld_d;

  assign dl_rise   = I_DL & ~dl_q;
  assign in_lane   = I_ADDR[2:0];
  assign in_waddr  = I_ADDR[ADDR_W-1:3];
  assign accept    = (state_q == ST_COLLECT) & I_DL & I_WR & ~out_vld;
  assign same_word = buf_vld & (buf_waddr == in_waddr);

  assign O_WAIT         = out_vld;
  assign DDRAM_WE       = out_vld;
  assign DDRAM_BURSTCNT = 8'd1;

  // Merge onto the live buffer only for the same word; otherwise start from a clean word.
  always_comb begin
    merged_dat = same_word ? buf_dat : 64'h0;
    merged_be  = same_word ? buf_be  : 8'h00;
    merged_dat[8*in_lane +: 8] = I_DATA;
    merged_be[in_lane]         = 1'b1;
  end

  always_comb begin
    ho_vld    = 1'b0;
    ho_waddr  = buf_waddr;
    ho_dat    = buf_dat;
    ho_be     = buf_be;
    buf_load  = 1'b0;
    buf_vld_d = buf_vld;
    if (accept) begin
      if (buf_vld && !same_word) begin
        ho_vld    = 1'b1;
        buf_load  = 1'b1;
        buf_vld_d = 1'b1;
      end else if (in_lane == 3'd7) begin
        ho_vld    = 1'b1;
        ho_waddr  = in_waddr;
        ho_dat    = merged_dat;
        ho_be     = merged_be;
        buf_vld_d = 1'b0;
      end else begin
        buf_load  = 1'b1;
        buf_vld_d = 1'b1;
      end
    end else if (state_q == ST_FLUSH && buf_vld && !out_vld) begin
      ho_vld    = 1'b1;
      buf_vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (dl_rise) state_d = ST_COLLECT;
      ST_COLLECT: if (!I_DL) state_d = ST_FLUSH;
      ST_FLUSH:   if (!buf_vld && !out_vld) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= ST_IDLE;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= I_DL;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      buf_vld   <= 1'b0;
      buf_waddr <= '0;
      buf_dat   <= 64'h0;
      buf_be    <= 8'h00;
    end else begin
      buf_vld <= buf_vld_d;
      if (buf_load) begin
        buf_waddr <= in_waddr;
        buf_dat   <= merged_dat;
        buf_be    <= merged_be;
      end
    end
  end

  // Output stage holds ADDR/DIN/BE stable until the controller takes the beat.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      out_vld    <= 1'b0;
      DDRAM_ADDR <= 29'h0;
      DDRAM_DIN  <= 64'h0;
      DDRAM_BE   <= 8'h00;
    end else if (ho_vld) begin
      out_vld    <= 1'b1;
      DDRAM_ADDR <= BASE_WADDR + 29'(ho_waddr);
      DDRAM_DIN  <= ho_dat;
      DDRAM_BE   <= ho_be;
    end else if (out_vld && !DDRAM_BUSY) begin
      out_vld <= 1'b0;
    end
  end

`ifdef DDRAM_BYTE_WRITER_CKSUM_EN
  logic [15:0] cksum_q;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      cksum_q <= 16'h0000;
    end else if (dl_rise) begin
      cksum_q <= 16'h0000;
    end else if (accept) begin
      cksum_q <= cksum_q + {8'h00, I_DATA};
    end
  end

  assign O_CKSUM = cksum_q;
`else
  assign O_CKSUM = 16'h0000;
`endif

endmodule

// File: tb/tb_ddram_byte_writer.sv
// Directed bench for ddram_byte_writer: expected DDRAM writes queued at stimulus time, checked on completion.
module tb_ddram_byte_writer;

  localparam logic [28:0] BASE = 29'h0600_0000;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        I_DL, I_WR, DDRAM_BUSY;
  logic [24:0] I_ADDR;
  logic [7:0]  I_DATA;
  logic        O_WAIT, DDRAM_WE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE, DDRAM_BURSTCNT;
  logic [15:0] O_CKSUM;

  int  checks = 0;
  int  failures = 0;
  int  wr_cnt = 0;
  int  we_hi_cnt = 0;
  int  wait_cnt = 0;
  int  prev_wr;
  wr_t exp_q[$];
  wr_t got;

  always #5 clk = ~clk;

  ddram_byte_writer dut (
    .I_CLK(clk), .I_RSTn(rst_n), .I_DL(I_DL), .I_WR(I_WR), .I_ADDR(I_ADDR),
    .I_DATA(I_DATA), .O_WAIT(O_WAIT), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_WE(DDRAM_WE),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .O_CKSUM(O_CKSUM)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
    wr_t e;
    e.addr = a;
    e.din  = d;
    e.be   = b;
    exp_q.push_back(e);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (O_WAIT && n < 200) begin
      step();
      n++;
    end
    if (O_WAIT) chk("wait_timeout", {63'h0, O_WAIT}, 64'h0);
    I_WR = 1'b1;
    I_ADDR = a;
    I_DATA = d;
    step();
    I_WR = 1'b0;
  endtask

  // A beat completes at the posedge following a negedge that sees WE high and BUSY low.
  always @(negedge clk) begin
    if (rst_n) begin
      if (DDRAM_WE) we_hi_cnt++;
      if (O_WAIT) wait_cnt++;
      if (DDRAM_WE && !DDRAM_BUSY) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_write observed=%h/%h/%h expected=none", DDRAM_ADDR, DDRAM_DIN, DDRAM_BE);
        end
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          checks++;
          assert ({DDRAM_ADDR, DDRAM_DIN, DDRAM_BE} === got) else begin
            failures++;
            $error("FAIL write_data observed=%h/%h/%h expected=%h/%h/%h",
                   DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, got.addr, got.din, got.be);
          end
        end
        wr_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; I_DL = 1'b0; I_WR = 1'b0; I_ADDR = '0; I_DATA = '0; DDRAM_BUSY = 1'b0;
    #23;
    chk("rst_we",    {63'h0, DDRAM_WE}, 64'h0);
    chk("rst_wait",  {63'h0, O_WAIT}, 64'h0);
    chk("rst_addr",  {35'h0, DDRAM_ADDR}, 64'h0);
    chk("rst_din",   DDRAM_DIN, 64'h0);
    chk("rst_be",    {56'h0, DDRAM_BE}, 64'h0);
    chk("rst_cksum", {48'h0, O_CKSUM}, 64'h0);
    chk("burstcnt",  {56'h0, DDRAM_BURSTCNT}, 64'h1);
    step();
    rst_n = 1'b1;
    step();

    // 1: full word, lane 7 triggers the write
    I_DL = 1'b1;
    step();
    we_hi_cnt = 0;
    push(BASE, 64'h8877665544332211, 8'hFF);
    for (int i = 0; i < 8; i++) wr_byte(25'(i), 8'(8'h11 * (i + 1)));
    wait_n(4);
    chk("t1_wr_cnt", 64'(wr_cnt), 64'd1);
    chk("t1_we_cycles", 64'(we_hi_cnt), 64'd1);

    // 2: partial word flushed when download ends
    wr_byte(25'h10, 8'h11);
    wr_byte(25'h11, 8'h22);
    wr_byte(25'h12, 8'h33);
    chk("t2_no_early_write", 64'(wr_cnt), 64'd1);
    push(BASE + 29'd2, 64'h0000_0000_0033_2211, 8'h07);
    I_DL = 1'b0;
    wait_n(6);
    chk("t2_wr_cnt", 64'(wr_cnt), 64'd2);
    chk("t2_idle", 64'(int'(dut.state_q)), 64'd0);

    // 3: word change pushes the old buffer out, flush sends the new one
    I_DL = 1'b1;
    step();
    push(BASE, 64'h0000_AB00_0000_0000, 8'h20);
    wr_byte(25'h05, 8'hAB);
    wr_byte(25'h20, 8'hCD);
    wait_n(3);
    chk("t3_first", 64'(wr_cnt), 64'd3);
    push(BASE + 29'd4, 64'h0000_0000_0000_00CD, 8'h01);
    I_DL = 1'b0;
    wait_n(6);
    chk("t3_flush", 64'(wr_cnt), 64'd4);

    // 4: busy controller stalls the output stage, stalled strobe dropped
    I_DL = 1'b1;
    step();
    DDRAM_BUSY = 1'b1;
    wait_cnt = 0;
    push(BASE + 29'd8, 64'hA7A6_A5A4_A3A2_A1A0, 8'hFF);
    for (int i = 0; i < 8; i++) wr_byte(25'h40 + 25'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      chk("t4_we",   {63'h0, DDRAM_WE}, 64'h1);
      chk("t4_addr", {35'h0, DDRAM_ADDR}, {35'h0, BASE + 29'd8});
      chk("t4_din",  DDRAM_DIN, 64'hA7A6_A5A4_A3A2_A1A0);
      chk("t4_be",   {56'h0, DDRAM_BE}, 64'hFF);
      if (i == 0) begin
        I_WR = 1'b1;
        I_ADDR = 25'h48;
        I_DATA = 8'h5A;
      end
      step();
      I_WR = 1'b0;
    end
    DDRAM_BUSY = 1'b0;
    step();
    chk("t4_we_drop", {63'h0, DDRAM_WE}, 64'h0);
    chk("t4_wait_cycles", 64'(wait_cnt), 64'd11);
    I_DL = 1'b0;
    wait_n(6);
    chk("t4_wr_cnt", 64'(wr_cnt), 64'd5);
    chk("t4_idle", 64'(int'(dut.state_q)), 64'd0);

    // 5: reset during a stalled write discards everything
    I_DL = 1'b1;
    step();
    DDRAM_BUSY = 1'b1;
    wr_byte(25'h60, 8'h01);
    wr_byte(25'h61, 8'h02);
    wr_byte(25'h62, 8'h03);
    I_DL = 1'b0;
    wait_n(3);
    chk("t5_we_before", {63'h0, DDRAM_WE}, 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_we_async", {63'h0, DDRAM_WE}, 64'h0);
    chk("t5_wait_async", {63'h0, O_WAIT}, 64'h0);
    wait_n(2);
    DDRAM_BUSY = 1'b0;
    rst_n = 1'b1;
    step();
    prev_wr = wr_cnt;
    I_DL = 1'b1;
    wait_n(2);
    I_DL = 1'b0;
    wait_n(8);
    chk("t5_no_write", 64'(wr_cnt), 64'(prev_wr));
    chk("t5_idle", 64'(int'(dut.state_q)), 64'd0);

`ifdef DDRAM_BYTE_WRITER_CKSUM_EN
    // 6: 258 x 0xFF wraps to 0x00FE; new download clears it
    I_DL = 1'b1;
    step();
    chk("t6_cleared", {48'h0, O_CKSUM}, 64'h0);
    for (int i = 0; i < 258; i++) begin
      logic [24:0] a;
      a = 25'h100 + 25'(i);
      if (a[2:0] == 3'd7) push(BASE + 29'(a[24:3]), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      wr_byte(a, 8'hFF);
    end
    push(BASE + 29'h40, 64'h0000_0000_0000_FFFF, 8'h03);
    I_DL = 1'b0;
    wait_n(8);
    chk("t6_cksum_held", {48'h0, O_CKSUM}, 64'h00FE);
    I_DL = 1'b1;
    wait_n(2);
    chk("t6_cksum_rise", {48'h0, O_CKSUM}, 64'h0);
    I_DL = 1'b0;
    wait_n(6);
`else
    I_DL = 1'b1;
    step();
    wr_byte(25'h80, 8'h5A);
    push(BASE + 29'h10, 64'h0000_0000_0000_005A, 8'h01);
    I_DL = 1'b0;
    wait_n(6);
    chk("t6_cksum_tied", {48'h0, O_CKSUM}, 64'h0);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
